// File: rtl/capture_writer_if.sv
// AXI4 write-only bus between the frame-capture DMA master and its memory slave.
interface capture_writer_if;
  logic        M_AXI_AWID;
  logic [31:0] M_AXI_AWADDR;
  logic [7:0]  M_AXI_AWLEN;
  logic [2:0]  M_AXI_AWSIZE;
  logic [1:0]  M_AXI_AWBURST;
  logic        M_AXI_AWLOCK;
  logic [3:0]  M_AXI_AWCACHE;
  logic [2:0]  M_AXI_AWPROT;
  logic [3:0]  M_AXI_AWQOS;
  logic        M_AXI_AWUSER;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WLAST;
  logic        M_AXI_WUSER;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY;
  logic        M_AXI_BID;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BUSER;
  logic        M_AXI_BVALID;
  logic        M_AXI_BREADY;

  modport master (
    output M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWLOCK,
           M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS, M_AXI_AWUSER, M_AXI_AWVALID,
           M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WUSER, M_AXI_WVALID, M_AXI_BREADY,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BID, M_AXI_BRESP, M_AXI_BUSER, M_AXI_BVALID
  );

  modport slave (
    input  M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWLOCK,
           M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS, M_AXI_AWUSER, M_AXI_AWVALID,
           M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WUSER, M_AXI_WVALID, M_AXI_BREADY,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BID, M_AXI_BRESP, M_AXI_BUSER, M_AXI_BVALID
  );
endinterface

// File: rtl/capture_writer.sv
// Frame-capture DMA master: packs 0x0RGB pixels two per word into a FIFO and writes one frame
// to memory with fixed-length INCR bursts, one burst outstanding at a time.
module capture_writer #(
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN          = 16,
  parameter int unsigned FIFO_DEPTH         = 64,
  parameter int unsigned H_PIXELS           = 640,
  parameter int unsigned V_LINES            = 480
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  capture_writer_if.master  axi,
  input  logic [15:0]       PIX_DATA,
  input  logic              PIX_SOF,
  input  logic              PIX_VALID,
  output logic              PIX_READY,
  input  logic [27:0]       CAPADDR,
  input  logic              CAPON,
  input  logic              CLRDONE,
  output logic              DONE,
  output logic              BRESP_ERR
);

  localparam int unsigned NumPix     = H_PIXELS * V_LINES;
  localparam int unsigned NumBursts  = NumPix / 2 / BURST_LEN;
  localparam int unsigned PixW       = $clog2(NumPix);
  localparam int unsigned BurstW     = $clog2(NumBursts + 1);
  localparam int unsigned BeatW      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned PtrW       = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW       = PtrW + 1;
  localparam logic [31:0] BurstBytes = 32'(BURST_LEN * 4);

  typedef enum logic [1:0] {StIdle, StArmed, StRun, StFlush} in_state_e;
  typedef enum logic [1:0] {StWIdle, StWAddr, StWData, StWResp} wr_state_e;

  in_state_e in_state_q, in_state_d;
  wr_state_e wr_state_q, wr_state_d;

  logic [PixW-1:0]               pix_cnt_q, pix_cnt_d;
  logic [15:0]                   pix_lo_q, pix_lo_d;
  logic [PtrW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]               cnt_q, cnt_d;
  logic [BeatW-1:0]              beat_q, beat_d;
  logic [BurstW-1:0]             burst_cnt_q, burst_cnt_d;
  logic [31:0]                   awaddr_q, awaddr_d;
  logic                          done_q, done_d, err_q, err_d;
  logic [C_M_AXI_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic pix_ready, fifo_full, pix_fire, push, pop, arm;
  logic awvalid, wvalid, wlast, bready;
  logic aw_fire, w_fire, b_fire, frame_end;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign fifo_full = (cnt_q == CntW'(FIFO_DEPTH));
  assign pix_fire  = PIX_VALID && pix_ready;
  // Words are pushed on the odd pixel of each pair; the even one waits in pix_lo_q.
  assign push      = pix_fire && (in_state_q == StRun) && pix_cnt_q[0];
  assign pop       = w_fire;
  assign arm       = (in_state_q == StIdle) && CAPON && !done_q;
  assign aw_fire   = awvalid && axi.M_AXI_AWREADY;
  assign w_fire    = wvalid && axi.M_AXI_WREADY;
  assign b_fire    = bready && axi.M_AXI_BVALID;
  assign frame_end = b_fire && (burst_cnt_q == BurstW'(NumBursts - 1));

  // State registers
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      in_state_q <= StIdle;
      wr_state_q <= StWIdle;
    end else begin
      in_state_q <= in_state_d;
      wr_state_q <= wr_state_d;
    end
  end

  always_comb begin
    in_state_d = in_state_q;
    unique case (in_state_q)
      StIdle:  if (arm) in_state_d = StArmed;
      StArmed: begin
        if (pix_fire && PIX_SOF) in_state_d = StRun;
        else if (!CAPON)         in_state_d = StIdle;
      end
      StRun:   if (pix_fire && pix_cnt_q == PixW'(NumPix - 1)) in_state_d = StFlush;
      StFlush: if (frame_end) in_state_d = StIdle;
      default: in_state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_state_d = wr_state_q;
    unique case (wr_state_q)
      StWIdle: if (cnt_q >= CntW'(BURST_LEN)) wr_state_d = StWAddr;
      StWAddr: if (aw_fire) wr_state_d = StWData;
      StWData: if (w_fire && wlast) wr_state_d = StWResp;
      StWResp: if (b_fire) wr_state_d = StWIdle;
      default: wr_state_d = StWIdle;
    endcase
  end

  // Output decode
  always_comb begin
    pix_ready = 1'b0;
    unique case (in_state_q)
      StArmed: pix_ready = 1'b1;
      StRun:   pix_ready = !fifo_full;
      default: pix_ready = 1'b0;
    endcase
  end

  always_comb begin
    awvalid = (wr_state_q == StWAddr);
    wvalid  = (wr_state_q == StWData);
    bready  = (wr_state_q == StWResp);
    wlast   = wvalid && (beat_q == BeatW'(BURST_LEN - 1));
  end

  // Datapath next-state
  always_comb begin
    pix_cnt_d   = pix_cnt_q;
    pix_lo_d    = pix_lo_q;
    burst_cnt_d = burst_cnt_q;
    awaddr_d    = awaddr_q;
    beat_d      = beat_q;
    wr_ptr_d    = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d       = cnt_q + CntW'(push) - CntW'(pop);
    if (arm) begin
      burst_cnt_d = '0;
      awaddr_d    = {CAPADDR, 4'h0};
    end
    if (pix_fire) begin
      if (in_state_q == StArmed && PIX_SOF) begin
        pix_lo_d  = PIX_DATA;
        pix_cnt_d = PixW'(1);
      end else if (in_state_q == StRun) begin
        if (!pix_cnt_q[0]) pix_lo_d = PIX_DATA;
        pix_cnt_d = pix_cnt_q + PixW'(1);
      end
    end
    if (w_fire) beat_d = wlast ? '0 : beat_q + BeatW'(1);
    if (b_fire) begin
      burst_cnt_d = burst_cnt_q + BurstW'(1);
      awaddr_d    = awaddr_q + BurstBytes;
    end
    done_d = frame_end || (done_q && !CLRDONE);
    err_d  = (b_fire && axi.M_AXI_BRESP != 2'b00) || (err_q && !CLRDONE);
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      pix_cnt_q   <= '0;
      pix_lo_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      beat_q      <= '0;
      burst_cnt_q <= '0;
      awaddr_q    <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      pix_cnt_q   <= pix_cnt_d;
      pix_lo_q    <= pix_lo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      beat_q      <= beat_d;
      burst_cnt_q <= burst_cnt_d;
      awaddr_q    <= awaddr_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge ACLK) begin
    if (push) mem_q[wr_ptr_q] <= {PIX_DATA, pix_lo_q};
  end

  assign PIX_READY = pix_ready;
  assign DONE      = done_q;
  assign BRESP_ERR = err_q;

  assign axi.M_AXI_AWID    = 1'b0;
  assign axi.M_AXI_AWUSER  = 1'b0;
  assign axi.M_AXI_WUSER   = 1'b0;
  assign axi.M_AXI_AWADDR  = awaddr_q;
  assign axi.M_AXI_AWLEN   = 8'(BURST_LEN - 1);
  assign axi.M_AXI_AWSIZE  = 3'b010;
  assign axi.M_AXI_AWBURST = 2'b01;
  assign axi.M_AXI_AWLOCK  = 1'b0;
  assign axi.M_AXI_AWCACHE = 4'b0011;
  assign axi.M_AXI_AWPROT  = 3'b000;
  assign axi.M_AXI_AWQOS   = 4'h0;
  assign axi.M_AXI_AWVALID = awvalid;
  // FIFO head shown only while a beat is offered, so WDATA idles at zero.
  assign axi.M_AXI_WDATA   = wvalid ? mem_q[rd_ptr_q] : '0;
  assign axi.M_AXI_WSTRB   = 4'hF;
  assign axi.M_AXI_WLAST   = wlast;
  assign axi.M_AXI_WVALID  = wvalid;
  assign axi.M_AXI_BREADY  = bready;

  logic unused_b;
  assign unused_b = ^{axi.M_AXI_BID, axi.M_AXI_BUSER};

endmodule

// File: tb/tb_capture_writer.sv
// Bench for capture_writer: random pixel stream and stalling AXI slave, with a scoreboard
// checking every AW/W beat and the final memory image against a frame-level model.
module tb_capture_writer;
  localparam int H = 32, V = 4, NPIX = H * V, NWORDS = NPIX / 2, BL = 16, NBURST = NWORDS / BL;
  localparam int DEPTH = 64;

  logic        clk = 1'b0, rstn = 1'b0;
  logic [15:0] pix_data = '0;
  logic        pix_sof = 1'b0, pix_valid = 1'b0, pix_ready;
  logic [27:0] capaddr = '0;
  logic        capon = 1'b0, clrdone = 1'b0, done, bresp_err;

  capture_writer_if axi();

  capture_writer #(.C_M_AXI_DATA_WIDTH(32), .BURST_LEN(BL), .FIFO_DEPTH(DEPTH),
                   .H_PIXELS(H), .V_LINES(V)) dut (
    .ACLK(clk), .ARESETN(rstn), .axi(axi), .PIX_DATA(pix_data), .PIX_SOF(pix_sof),
    .PIX_VALID(pix_valid), .PIX_READY(pix_ready), .CAPADDR(capaddr), .CAPON(capon),
    .CLRDONE(clrdone), .DONE(done), .BRESP_ERR(bresp_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // Knobs owned by the stimulus process.
  int vpct = 100, aw_pct = 100, w_pct = 100, aw_block_until = 0, err_burst = -1;
  logic [15:0] px [NPIX];

  // Slave BFM + scoreboard state, owned by the monitor process.
  int          cyc = 0, beat = 0, occ = 0, cap_idx = 0, b_cnt = 0;
  bit          b_pend = 0, b_hs_prev = 0;
  logic [15:0] lo = '0;
  logic [31:0] cur_addr = '0;
  logic [31:0] exp_addr_q [$];
  logic [31:0] exp_word_q [$];
  logic [31:0] ram [logic [31:0]];

  // Everything here runs 3 time units after the edge: DUT outputs and bench inputs are stable,
  // readies are chosen, so every handshake for the coming edge is known.
  always begin
    @(posedge clk);
    #3;
    cyc++;
    if (!rstn) begin
      axi.M_AXI_AWREADY = 1'b0;
      axi.M_AXI_WREADY  = 1'b0;
      axi.M_AXI_BVALID  = 1'b0;
      axi.M_AXI_BRESP   = 2'b00;
      axi.M_AXI_BID     = 1'b0;
      axi.M_AXI_BUSER   = 1'b0;
      b_pend = 0; b_hs_prev = 0; beat = 0; occ = 0; cap_idx = 0; b_cnt = 0;
      exp_addr_q.delete();
      exp_word_q.delete();
    end else begin
      if (b_hs_prev) begin
        axi.M_AXI_BVALID = 1'b0;
        b_hs_prev = 0;
      end
      axi.M_AXI_AWREADY = (cyc >= aw_block_until) && ($urandom_range(99) < aw_pct);
      axi.M_AXI_WREADY  = $urandom_range(99) < w_pct;
      if (b_pend && !axi.M_AXI_BVALID) begin
        axi.M_AXI_BVALID = 1'b1;
        axi.M_AXI_BRESP  = (b_cnt == err_burst) ? 2'b10 : 2'b00;
      end

      if (cap_idx > 0 && cap_idx < NPIX) check("pix_ready_run", pix_ready, occ != DEPTH);

      if (pix_valid && pix_ready) begin
        if (cap_idx == 0 || cap_idx == NPIX) begin
          if (pix_sof) begin
            lo = pix_data;
            cap_idx = 1;
            b_cnt = 0;
            exp_addr_q.delete();
            for (int k = 0; k < NBURST; k++) exp_addr_q.push_back({capaddr, 4'h0} + 32'(k * 64));
          end
        end else begin
          if (cap_idx % 2 == 0) lo = pix_data;
          else begin
            exp_word_q.push_back({pix_data, lo});
            occ++;
          end
          cap_idx++;
        end
      end

      if (axi.M_AXI_AWVALID && axi.M_AXI_AWREADY) begin
        if (exp_addr_q.size() == 0) check("aw_unexpected", axi.M_AXI_AWADDR, 32'hFFFF_FFFF);
        else check("awaddr", axi.M_AXI_AWADDR, exp_addr_q.pop_front());
        check("awlen", 32'(axi.M_AXI_AWLEN), BL - 1);
        check("awsize_burst_cache", {axi.M_AXI_AWSIZE, axi.M_AXI_AWBURST, axi.M_AXI_AWCACHE},
              {3'b010, 2'b01, 4'b0011});
        cur_addr = axi.M_AXI_AWADDR;
        beat = 0;
      end

      if (axi.M_AXI_WVALID && axi.M_AXI_WREADY) begin
        if (exp_word_q.size() == 0) check("w_unexpected", axi.M_AXI_WDATA, 32'hFFFF_FFFF);
        else check("wdata", axi.M_AXI_WDATA, exp_word_q.pop_front());
        check("wlast", axi.M_AXI_WLAST, beat == BL - 1);
        check("wstrb", axi.M_AXI_WSTRB, 4'hF);
        ram[cur_addr + 32'(4 * beat)] = axi.M_AXI_WDATA;
        beat++;
        occ--;
        if (axi.M_AXI_WLAST) b_pend = 1;
      end

      if (axi.M_AXI_BVALID && axi.M_AXI_BREADY) begin
        b_pend = 0;
        b_hs_prev = 1;
        b_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_awvalid", axi.M_AXI_AWVALID, 0);
    check("rst_wvalid", axi.M_AXI_WVALID, 0);
    check("rst_wlast", axi.M_AXI_WLAST, 0);
    check("rst_bready", axi.M_AXI_BREADY, 0);
    check("rst_pix_ready", pix_ready, 0);
    check("rst_done", done, 0);
    check("rst_bresp_err", bresp_err, 0);
    check("rst_awaddr", axi.M_AXI_AWADDR, 0);
    check("rst_wdata", axi.M_AXI_WDATA, 0);
  endtask

  // Streams one frame; abort_at >= 0 pulses reset once pixel abort_at has been accepted.
  task automatic run_frame(input logic [27:0] base, input bit idx_px, input int junk,
                           input bit sof_noise, input int abort_at);
    int  k, t;
    bit  fire;
    for (int i = 0; i < NPIX; i++) px[i] = idx_px ? 16'(i) : 16'($urandom_range(16'h0FFF));
    capaddr = base;
    capon = 1'b1;
    t = 0;
    tick();
    while (!pix_ready && t < 50) begin
      tick();
      t++;
    end
    check("armed_ready", pix_ready, 1);
    k = -junk;
    t = 0;
    while (k < NPIX && t < 20000) begin
      if (abort_at >= 0 && k > abort_at) begin
        pix_valid = 1'b0;
        rstn = 1'b0;
        capon = 1'b0;
        tick();
        rstn = 1'b1;
        check_reset_outputs();
        return;
      end
      pix_valid = ($urandom_range(99) < vpct);
      if (k < 0) begin
        pix_data = 16'($urandom_range(16'h0FFF));
        pix_sof  = 1'b0;
      end else begin
        pix_data = px[k];
        pix_sof  = (k == 0) ? 1'b1 : (sof_noise ? 1'($urandom_range(1)) : 1'b0);
      end
      if (k > 0) capon = 1'b0;
      fire = pix_valid && pix_ready;
      tick();
      t++;
      if (fire) k++;
    end
    pix_valid = 1'b0;
    pix_sof = 1'b0;
    check("pixels_accepted", k, NPIX);
  endtask

  task automatic finish_frame(input logic [27:0] base, input bit exp_err);
    int t = 0;
    logic [31:0] a, got;
    while (!done && t < 5000) begin
      tick();
      t++;
    end
    check("done", done, 1);
    check("bresp_err", bresp_err, exp_err);
    check("b_count", b_cnt, NBURST);
    for (int i = 0; i < NWORDS; i++) begin
      a = {base, 4'h0} + 32'(4 * i);
      got = ram.exists(a) ? ram[a] : 32'hDEAD_BEEF;
      check("ram", got, {px[2 * i + 1], px[2 * i]});
    end
    capon = 1'b1;
    repeat (3) tick();
    check("no_rearm_while_done", pix_ready, 0);
    capon = 1'b0;
    clrdone = 1'b1;
    tick();
    clrdone = 1'b0;
    check("clr_done", done, 0);
    check("clr_bresp_err", bresp_err, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
    check_reset_outputs();
    check("const_ids", {axi.M_AXI_AWID, axi.M_AXI_AWUSER, axi.M_AXI_WUSER, axi.M_AXI_AWLOCK,
                        axi.M_AXI_AWPROT, axi.M_AXI_AWQOS}, 0);

    // Ideal stream, index pixels, base 0.
    run_frame(28'h0, 1, 0, 0, -1);
    finish_frame(28'h0, 0);
    // Base 0x1000, random pixels, spurious SOF inside the frame.
    run_frame(28'h100, 0, 0, 1, -1);
    finish_frame(28'h100, 0);
    // Junk pixels while armed are dropped.
    run_frame(28'h200, 1, 3, 0, -1);
    finish_frame(28'h200, 0);
    // Bursty source and stalling slave; AW held off long enough for the FIFO to fill.
    vpct = 50; aw_pct = 50; w_pct = 50;
    aw_block_until = cyc + 300;
    run_frame(28'h300, 1, 0, 0, -1);
    finish_frame(28'h300, 0);
    vpct = 100; aw_pct = 100; w_pct = 100;
    // Error response on burst 2.
    err_burst = 2;
    run_frame(28'h400, 0, 0, 0, -1);
    finish_frame(28'h400, 1);
    err_burst = -1;
    // Reset mid-frame, then a clean recapture over the same base.
    w_pct = 70;
    run_frame(28'h500, 1, 0, 0, 40);
    repeat (2) tick();
    run_frame(28'h500, 0, 0, 0, -1);
    finish_frame(28'h500, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
